// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared types and constants for the serial ALU helpers
// Rev 1.0 : initial release
// ============================================================================
package alu_pkg;

   localparam int unsigned c_default_width = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter must reach WIDTH itself, hence the +1.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_negate_cell.sv
`default_nettype none
// ============================================================================
// serial_negate_cell : one-bit serial two's-complement negation step
// Rev 1.0 : initial release
// ============================================================================
module serial_negate_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic bit_in,
   input  logic negate,
   input  logic clear,
   output logic bit_out
);

   logic seen_one_q, seen_one_d;

   // Copy bits up to and including the first 1, invert everything after it.
   always_comb begin
      seen_one_d = clear ? 1'b0 : (seen_one_q | bit_in);
      bit_out    = bit_in ^ (negate & seen_one_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_one_q <= 1'b0;
      end else begin
         seen_one_q <= seen_one_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/serial_signmag_decoder.sv
`default_nettype none
// ============================================================================
// serial_signmag_decoder : LSB-first bit-serial two's-complement to sign-magnitude
// Rev 1.0 : initial release
// ============================================================================
module serial_signmag_decoder
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = c_default_width
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_sign,
   output logic [WIDTH-1:0] out_mag,
   output logic             out_min,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned      CNT_W  = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH);
   localparam logic [WIDTH-1:0] c_min  = {1'b1, {(WIDTH-1){1'b0}}};

   state_e           state_q, state_d;
   logic             ready_en_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic             sign_q, sign_d;
   logic             out_sign_q, out_sign_d;
   logic [WIDTH-1:0] out_mag_q, out_mag_d;
   logic             out_min_q, out_min_d;
   logic             accept;
   logic             bits_done;
   logic             result_bit;

   assign accept    = in_valid & in_ready;
   assign bits_done = (cnt_q == c_last);

   serial_negate_cell u_negate_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .bit_in  (shift_q[0]),
      .negate  (sign_q),
      .clear   (accept),
      .bit_out (result_bit)
   );

   // State register; ready_en_q keeps in_ready low until the first edge out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = RUN;
         RUN:     if (bits_done) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE) & ready_en_q;
      out_valid = (state_q == DONE);
      out_sign  = out_sign_q;
      out_mag   = out_mag_q;
      out_min   = out_min_q;
   end

   // Result bits enter work_q at the MSB so the LSB-first walk lands in place.
   always_comb begin
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      work_d     = work_q;
      sign_d     = sign_q;
      out_sign_d = out_sign_q;
      out_mag_d  = out_mag_q;
      out_min_d  = out_min_q;
      if (accept) begin
         shift_d = in_data;
         sign_d  = in_data[WIDTH-1];
         cnt_d   = '0;
         work_d  = '0;
      end else if (state_q == RUN) begin
         if (!bits_done) begin
            shift_d = {1'b0, shift_q[WIDTH-1:1]};
            work_d  = {result_bit, work_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
         end else begin
            out_sign_d = sign_q;
            out_mag_d  = work_q;
            out_min_d  = sign_q & (work_q == c_min);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         shift_q    <= '0;
         work_q     <= '0;
         sign_q     <= 1'b0;
         out_sign_q <= 1'b0;
         out_mag_q  <= '0;
         out_min_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         work_q     <= work_d;
         sign_q     <= sign_d;
         out_sign_q <= out_sign_d;
         out_mag_q  <= out_mag_d;
         out_min_q  <= out_min_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_signmag_decoder.sv
`default_nettype none
// ============================================================================
// tb_serial_signmag_decoder : self-checking bench for serial_signmag_decoder
// Rev 1.0 : initial release
// ============================================================================
module tb_serial_signmag_decoder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         out_sign;
   logic [W-1:0] out_mag;
   logic         out_min;
   logic         out_valid;
   logic         out_ready;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   serial_signmag_decoder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_sign  (out_sign),
      .out_mag   (out_mag),
      .out_min   (out_min),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   typedef struct {
      logic [W-1:0] data;
      logic         sign;
      logic [W-1:0] mag;
      logic         min;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: signed value from the bit pattern, then plain abs().
   task automatic model(input logic [W-1:0] x, output logic s, output logic [W-1:0] m,
                        output logic mn);
      int v;
      v  = (int'(x) >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
      s  = (v < 0);
      m  = W'((v < 0) ? -v : v);
      mn = (v == -(1 << (W - 1)));
   endtask

   task automatic send(input logic [W-1:0] d);
      int g = 0;
      while (!in_ready && g < 50) begin
         step();
         g++;
      end
      if (!in_ready) timeout("send");
      in_data  = d;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         step();
         lat++;
      end
      if (!out_valid) timeout("out_valid");
   endtask

   task automatic run_op(input logic [W-1:0] d, input int stall, output logic s,
                         output logic [W-1:0] m, output logic mn, output int lat);
      send(d);
      wait_result(lat);
      s  = out_sign;
      m  = out_mag;
      mn = out_min;
      repeat (stall) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic         s, mn, es, emn;
      logic [W-1:0] m, em, d;
      int           lat;

      vecs[0] = '{8'h00, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{8'h05, 1'b0, 8'h05, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 8'h01, 1'b0};
      vecs[3] = '{8'hFE, 1'b1, 8'h02, 1'b0};
      vecs[4] = '{8'h81, 1'b1, 8'h7F, 1'b0};
      vecs[5] = '{8'hC1, 1'b1, 8'h3F, 1'b0};
      vecs[6] = '{8'h87, 1'b1, 8'h79, 1'b0};
      vecs[7] = '{8'h80, 1'b1, 8'h80, 1'b1};
      vecs[8] = '{8'h7F, 1'b0, 8'h7F, 1'b0};

      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #23;
      check("rst.in_ready",  32'(in_ready),  32'd0);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.out_sign",  32'(out_sign),  32'd0);
      check("rst.out_mag",   32'(out_mag),   32'd0);
      check("rst.out_min",   32'(out_min),   32'd0);
      step();
      rst_n = 1'b1;
      #1;
      check("post_rst.in_ready_low", 32'(in_ready), 32'd0);
      step();
      check("post_rst.in_ready_high", 32'(in_ready), 32'd1);

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].data, 0, s, m, mn, lat);
         check($sformatf("vec%0d.sign", i),    32'(s),   32'(vecs[i].sign));
         check($sformatf("vec%0d.mag", i),     32'(m),   32'(vecs[i].mag));
         check($sformatf("vec%0d.min", i),     32'(mn),  32'(vecs[i].min));
         check($sformatf("vec%0d.latency", i), 32'(lat), 32'(W + 1));
      end

      // Backpressure with a competing operand waiting on the input.
      send(8'hFE);
      wait_result(lat);
      in_data  = 8'h33;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("bp%0d.out_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("bp%0d.in_ready", i),  32'(in_ready),  32'd0);
         check($sformatf("bp%0d.out_mag", i),   32'(out_mag),   32'h02);
         check($sformatf("bp%0d.out_sign", i),  32'(out_sign),  32'd1);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp.release.out_valid", 32'(out_valid), 32'd0);
      check("bp.release.in_ready",  32'(in_ready),  32'd1);
      check("bp.release.mag_held",  32'(out_mag),   32'h02);
      step();
      in_valid = 1'b0;
      check("bp.second_accepted", 32'(in_ready), 32'd0);
      wait_result(lat);
      check("bp.second.latency", 32'(lat),      32'(W + 1));
      check("bp.second.sign",    32'(out_sign), 32'd0);
      check("bp.second.mag",     32'(out_mag),  32'h33);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Reset asserted while bit 3 is being processed.
      send(8'h6C);
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      check("midrst.out_valid", 32'(out_valid), 32'd0);
      check("midrst.in_ready",  32'(in_ready),  32'd0);
      check("midrst.out_mag",   32'(out_mag),   32'd0);
      step();
      check("midrst.hold.in_ready",  32'(in_ready),  32'd0);
      check("midrst.hold.out_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      run_op(8'h85, 1, s, m, mn, lat);
      check("midrst.0x85.sign",    32'(s),   32'd1);
      check("midrst.0x85.mag",     32'(m),   32'h7B);
      check("midrst.0x85.latency", 32'(lat), 32'(W + 1));

      for (int i = 0; i < 60; i++) begin
         d = W'($urandom);
         if (i == 0) d = 8'h80;
         if (i == 1) d = 8'h01;
         model(d, es, em, emn);
         run_op(d, int'($urandom_range(0, 3)), s, m, mn, lat);
         check($sformatf("rnd%0d(%02h).sign", i, d), 32'(s),  32'(es));
         check($sformatf("rnd%0d(%02h).mag", i, d),  32'(m),  32'(em));
         check($sformatf("rnd%0d(%02h).min", i, d),  32'(mn), 32'(emn));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
